fp_pre_align: RTL and testbench

FP_PRE_ALIGN -- requirements
Module: fp_pre_align

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/align_shift_sticky.sv | 28 ++
 rtl/fp_pre_align.sv | 151 +++++++++++++++
 tb/tb_fp_pre_align.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared single-precision field constants and decoded-operand type
// for the FP add/sub front end.
package fpu_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int AW       = FRAC_W + 3;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int FRAC_MSB = 22;
    localparam int FRAC_LSB = 0;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  eff_exp;
        logic              hidden;
        logic [FRAC_W-1:0] frac;
    } fp_dec_t;

    // Denormals and zero share effective exponent 1 with no hidden bit.
    function automatic fp_dec_t fp_decode(input logic [31:0] op);
        fp_dec_t d;
        d.sign    = op[SIGN_BIT];
        d.frac    = op[FRAC_MSB:FRAC_LSB];
        d.hidden  = |op[EXP_MSB:EXP_LSB];
        d.eff_exp = d.hidden ? op[EXP_MSB:EXP_LSB] : EXP_W'(1);
        return d;
    endfunction

endpackage

// File: rtl/align_shift_sticky.sv
// Right shifter that folds every shifted-out bit into bit 0.
// Shift amounts >= AW collapse the input to a single sticky bit.
module align_shift_sticky
    import fpu_pkg::*;
#(
    parameter int EXP_W  = fpu_pkg::EXP_W,
    parameter int FRAC_W = fpu_pkg::FRAC_W,
    localparam int AW    = FRAC_W + 3
) (
    input  logic [AW-1:0]    in,
    input  logic [EXP_W-1:0] amt,
    output logic [AW-1:0]    out
);

    logic [AW-1:0] w_shifted;
    logic [AW-1:0] w_lost_mask;
    logic          w_sticky;

    // Oversized shifts give zero shifted data and an all-ones mask,
    // so the same expression covers the diff >= AW case.
    always_comb begin
        w_shifted   = in >> amt;
        w_lost_mask = ~({AW{1'b1}} << amt);
        w_sticky    = |(in & w_lost_mask);
        out         = {w_shifted[AW-1:1], w_shifted[0] | w_sticky};
    end

endmodule

// File: rtl/fp_pre_align.sv
// Two-stage FP add/sub pre-alignment: magnitude swap in stage 1,
// sticky alignment shift of the smaller mantissa in stage 2.
module fp_pre_align
    import fpu_pkg::*;
#(
    parameter int EXP_W  = fpu_pkg::EXP_W,
    parameter int FRAC_W = fpu_pkg::FRAC_W,
    localparam int AW    = FRAC_W + 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic             sub_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    big_mant,
    output logic [AW-1:0]    small_mant,
    output logic [EXP_W-1:0] exp_big,
    output logic             sign_big,
    output logic             eff_sub,
    output logic             swapped
);

    fp_dec_t            w_dec_a;
    fp_dec_t            w_dec_b;
    fp_dec_t            w_big;
    logic [EXP_W-1:0]   w_small_exp;
    logic [AW-1:0]      w_small_raw;
    logic               w_swap;
    logic [EXP_W-1:0]   w_diff;
    logic               w_eff_sub;
    logic               w_sign_big;

    logic               w_s2_ld;
    logic               w_s1_adv;
    logic               w_s1_ld;
    logic [AW-1:0]      w_small_aligned;

    logic               r_s1_valid;
    logic [AW-1:0]      r_s1_big_mant;
    logic [AW-1:0]      r_s1_small_raw;
    logic [EXP_W-1:0]   r_s1_diff;
    logic [EXP_W-1:0]   r_s1_exp_big;
    logic               r_s1_sign_big;
    logic               r_s1_eff_sub;
    logic               r_s1_swapped;

    logic               r_s2_valid;
    logic [AW-1:0]      r_s2_big_mant;
    logic [AW-1:0]      r_s2_small_mant;
    logic [EXP_W-1:0]   r_s2_exp_big;
    logic               r_s2_sign_big;
    logic               r_s2_eff_sub;
    logic               r_s2_swapped;

    // Stage 1 datapath: decode, magnitude compare, route, exponent diff.
    always_comb begin
        w_dec_a     = fp_decode(op_a);
        w_dec_b     = fp_decode(op_b);
        w_swap      = {w_dec_b.eff_exp, w_dec_b.hidden, w_dec_b.frac}
                    > {w_dec_a.eff_exp, w_dec_a.hidden, w_dec_a.frac};
        w_big       = w_swap ? w_dec_b : w_dec_a;
        w_small_exp = w_swap ? w_dec_a.eff_exp : w_dec_b.eff_exp;
        w_small_raw = w_swap ? {w_dec_a.hidden, w_dec_a.frac, 2'b00}
                             : {w_dec_b.hidden, w_dec_b.frac, 2'b00};
        w_diff      = w_big.eff_exp - w_small_exp;
        w_eff_sub   = w_dec_a.sign ^ w_dec_b.sign ^ sub_op;
        w_sign_big  = w_big.sign ^ (w_swap & sub_op);
    end

    // A stage loads when empty or when its downstream drains this cycle.
    always_comb begin
        w_s2_ld  = ~r_s2_valid | out_ready;
        w_s1_adv = r_s1_valid & w_s2_ld;
        w_s1_ld  = ~r_s1_valid | w_s1_adv;
    end

    assign in_ready = w_s1_ld & ~rst;

    align_shift_sticky #(
        .EXP_W  (EXP_W),
        .FRAC_W (FRAC_W)
    ) u_shift (
        .in  (r_s1_small_raw),
        .amt (r_s1_diff),
        .out (w_small_aligned)
    );

    // Stage 1 register: capture routed operands on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid     <= 1'b0;
            r_s1_big_mant  <= '0;
            r_s1_small_raw <= '0;
            r_s1_diff      <= '0;
            r_s1_exp_big   <= '0;
            r_s1_sign_big  <= 1'b0;
            r_s1_eff_sub   <= 1'b0;
            r_s1_swapped   <= 1'b0;
        end else if (w_s1_ld) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_big_mant  <= {w_big.hidden, w_big.frac, 2'b00};
                r_s1_small_raw <= w_small_raw;
                r_s1_diff      <= w_diff;
                r_s1_exp_big   <= w_big.eff_exp;
                r_s1_sign_big  <= w_sign_big;
                r_s1_eff_sub   <= w_eff_sub;
                r_s1_swapped   <= w_swap;
            end
        end
    end

    // Stage 2 register: aligned result, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid      <= 1'b0;
            r_s2_big_mant   <= '0;
            r_s2_small_mant <= '0;
            r_s2_exp_big    <= '0;
            r_s2_sign_big   <= 1'b0;
            r_s2_eff_sub    <= 1'b0;
            r_s2_swapped    <= 1'b0;
        end else if (w_s2_ld) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_big_mant   <= r_s1_big_mant;
                r_s2_small_mant <= w_small_aligned;
                r_s2_exp_big    <= r_s1_exp_big;
                r_s2_sign_big   <= r_s1_sign_big;
                r_s2_eff_sub    <= r_s1_eff_sub;
                r_s2_swapped    <= r_s1_swapped;
            end
        end
    end

    // Outputs read as zero for the whole time reset is held.
    always_comb begin
        out_valid  = r_s2_valid & ~rst;
        big_mant   = rst ? '0 : r_s2_big_mant;
        small_mant = rst ? '0 : r_s2_small_mant;
        exp_big    = rst ? '0 : r_s2_exp_big;
        sign_big   = ~rst & r_s2_sign_big;
        eff_sub    = ~rst & r_s2_eff_sub;
        swapped    = ~rst & r_s2_swapped;
    end

endmodule

// File: tb/tb_fp_pre_align.sv
// Randomized bench for fp_pre_align with a scoreboard model
// plus directed literal vectors, backpressure and mid-flight reset.
module tb_fp_pre_align;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        sub_op;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] big_mant;
    logic [25:0] small_mant;
    logic [7:0]  exp_big;
    logic        sign_big;
    logic        eff_sub;
    logic        swapped;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [25:0] bm;
        logic [25:0] sm;
        logic [7:0]  eb;
        logic        sb;
        logic        es;
        logic        sw;
        int          arrive;
    } exp_t;

    exp_t q[$];

    fp_pre_align dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .sub_op     (sub_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .big_mant   (big_mant),
        .small_mant (small_mant),
        .exp_big    (exp_big),
        .sign_big   (sign_big),
        .eff_sub    (eff_sub),
        .swapped    (swapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    // IEEE magnitude order equals unsigned order of bits [30:0].
    function automatic exp_t model(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic s);
        exp_t r;
        logic [31:0] bg, sl;
        int eb, es, d;
        longint mb, ms, lost;
        r.sw = (b[30:0] > a[30:0]);
        bg   = r.sw ? b : a;
        sl   = r.sw ? a : b;
        eb   = (bg[30:23] == 0) ? 1 : int'(bg[30:23]);
        es   = (sl[30:23] == 0) ? 1 : int'(sl[30:23]);
        d    = eb - es;
        mb   = ((bg[30:23] != 0) ? 64'd8388608 : 64'd0) + bg[22:0];
        ms   = ((sl[30:23] != 0) ? 64'd8388608 : 64'd0) + sl[22:0];
        mb   = mb * 4;
        ms   = ms * 4;
        r.bm = mb[25:0];
        if (d >= 26) begin
            r.sm = (ms != 0) ? 26'd1 : 26'd0;
        end else begin
            lost = ms % (64'd1 << d);
            ms   = ms / (64'd1 << d);
            if (lost != 0) ms = ms | 64'd1;
            r.sm = ms[25:0];
        end
        r.eb     = eb[7:0];
        r.es     = a[31] ^ b[31] ^ s;
        r.sb     = bg[31] ^ (r.sw & s);
        r.arrive = 0;
        return r;
    endfunction

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        logic exp_ov;
        cyc++;
        if (rst) begin
            chk("rst_out_valid", {31'd0, out_valid}, 0);
            chk("rst_in_ready", {31'd0, in_ready}, 0);
            chk("rst_data", {6'd0, big_mant} | {6'd0, small_mant}
                | {24'd0, exp_big}
                | {29'd0, sign_big, eff_sub, swapped}, 0);
            q.delete();
        end else begin
            exp_ov = (q.size() > 0) && (cyc >= q[0].arrive + 2);
            chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            chk("in_ready", {31'd0, in_ready},
                {31'd0, !(q.size() == 2 && !out_ready)});
            if (out_valid && exp_ov) begin
                chk("big_mant", {6'd0, big_mant}, {6'd0, q[0].bm});
                chk("small_mant", {6'd0, small_mant}, {6'd0, q[0].sm});
                chk("exp_big", {24'd0, exp_big}, {24'd0, q[0].eb});
                chk("flags", {29'd0, sign_big, eff_sub, swapped},
                    {29'd0, q[0].sb, q[0].es, q[0].sw});
            end
            if (out_valid && out_ready && q.size() > 0)
                void'(q.pop_front());
            if (in_valid && in_ready) begin
                e = model(op_a, op_b, sub_op);
                e.arrive = cyc;
                q.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after acceptance.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic s, output int waits);
        bit ok = 0;
        waits    = 0;
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        sub_op   = s;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else waits++;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("send_timeout", 1, 0);
    endtask

    task automatic directed(input string nm,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic s, input logic [25:0] bm,
                            input logic [25:0] sm, input logic [7:0] eb,
                            input logic sw, input logic es,
                            input logic sb);
        exp_t m;
        int w;
        m = model(a, b, s);
        chk({nm, "_model_bm"}, {6'd0, m.bm}, {6'd0, bm});
        chk({nm, "_model_sm"}, {6'd0, m.sm}, {6'd0, sm});
        chk({nm, "_model_eb"}, {24'd0, m.eb}, {24'd0, eb});
        send(a, b, s, w);
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_ov_c1"}, {31'd0, out_valid}, 0);
        @(negedge clk);
        chk({nm, "_ov_c2"}, {31'd0, out_valid}, 1);
        chk({nm, "_bm"}, {6'd0, big_mant}, {6'd0, bm});
        chk({nm, "_sm"}, {6'd0, small_mant}, {6'd0, sm});
        chk({nm, "_eb"}, {24'd0, exp_big}, {24'd0, eb});
        chk({nm, "_sw"}, {31'd0, swapped}, {31'd0, sw});
        chk({nm, "_es"}, {31'd0, eff_sub}, {31'd0, es});
        chk({nm, "_sb"}, {31'd0, sign_big}, {31'd0, sb});
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        logic [7:0]  e;
        v = $urandom;
        case ($urandom_range(0, 3))
            0: e = 8'($urandom_range(0, 3));
            1: e = 8'($urandom_range(120, 135));
            2: e = 8'hFF;
            default: e = v[30:23];
        endcase
        v[30:23] = e;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  w;
        bit  acc;
        logic [31:0] bp_a [4];
        rst       = 1'b1;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        sub_op    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", {31'd0, in_ready}, 1);
        @(posedge clk);
        #1;

        directed("add3_1", 32'h40400000, 32'h3F800000, 1'b0,
                 26'h3000000, 26'h1000000, 8'h80, 0, 0, 0);
        directed("diff26", 32'h3E800001, 32'h4B800000, 1'b0,
                 26'h2000000, 26'h0000001, 8'h97, 1, 0, 0);
        directed("sub_sw", 32'h3F800000, 32'h3FC00000, 1'b1,
                 26'h3000000, 26'h2000000, 8'h7F, 1, 1, 1);
        directed("denorm", 32'h00000001, 32'h00800000, 1'b0,
                 26'h2000000, 26'h0000004, 8'h01, 1, 0, 0);
        directed("equal", 32'hC0A00000, 32'h40A00000, 1'b1,
                 26'h2800000, 26'h2800000, 8'h81, 0, 0, 1);

        bp_a[0] = 32'h3F800000;
        bp_a[1] = 32'h40000000;
        bp_a[2] = 32'h40400000;
        bp_a[3] = 32'h40800000;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(bp_a[i], 32'h3F000000, 1'b0, w);
                    if (i < 2)
                        chk("bp_no_stall", w, 0);
                    else if (i == 2)
                        chk("bp_stall", {31'd0, w > 0}, 1);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", q.size(), 0);

        out_ready = 1'b0;
        send(32'h41200000, 32'h3F800000, 1'b0, w);
        send(32'h42C80000, 32'hBF800000, 1'b1, w);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_stale", {31'd0, out_valid}, 0);
        end
        @(posedge clk);
        #1;

        acc = 0;
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                op_a     = rnd_op();
                op_b     = rnd_op();
                if ($urandom_range(0, 7) == 0)
                    op_b = {1'($urandom), op_a[30:0]};
                sub_op   = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("final_drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
